// File: rtl/rgb_fade_scheduler.sv
// rgb_fade_scheduler: fades RGB PWM duties through a keyframe table with dwell; RGB_FADE_GAMMA_EN squares the duty outputs.
module rgb_fade_scheduler #(
  parameter int CLK_DIV = 120000,
  parameter int N_KEYS  = 4,
  parameter int KEY_AW  = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [KEY_AW-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_busy,
  output logic [KEY_AW-1:0] o_key_idx,
  output logic              o_key_done,
  output logic [7:0]        o_red_duty,
  output logic [7:0]        o_green_duty,
  output logic [7:0]        o_blue_duty
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, FADE, DWELL} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic tick;
  logic [31:0] tbl [N_KEYS];
  logic [31:0] key;
  logic [2:0][7:0] lin, lin_nx, tgt, step;
  logic [7:0] dwell_cnt, dwell_nx;
  logic [KEY_AW-1:0] idx_nx;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_tbl
    always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) tbl[k] <= '0;
      else if (i_wr_en && int'(i_wr_addr) == k) tbl[k] <= i_wr_data;
  end

  assign tick   = state != IDLE && cnt == CW'(CLK_DIV - 1);
  assign key    = tbl[o_key_idx];
  assign tgt    = key[23:0];
  assign o_busy = state != IDLE;

  always_comb begin
    step = lin;
    for (int i = 0; i < 3; i++)
      step[i] = lin[i] < tgt[i] ? lin[i] + 8'd1 : lin[i] > tgt[i] ? lin[i] - 8'd1 : lin[i];
  end

  // Stop has priority over everything, including a tick in the same cycle.
  always_comb begin
    state_nx   = state;
    lin_nx     = lin;
    dwell_nx   = dwell_cnt;
    idx_nx     = o_key_idx;
    o_key_done = 1'b0;
    if (i_stop) state_nx = IDLE;
    else if (state == IDLE) begin
      if (i_start) begin
        state_nx = FADE;
        idx_nx   = '0;
      end
    end else if (tick && state == FADE) begin
      lin_nx = step;
      if (step == tgt) begin
        state_nx = DWELL;
        dwell_nx = key[31:24];
      end
    end else if (tick) begin
      if (dwell_cnt == 8'd0) begin
        o_key_done = 1'b1;
        idx_nx     = o_key_idx == KEY_AW'(N_KEYS - 1) ? '0 : o_key_idx + KEY_AW'(1);
        state_nx   = FADE;
      end else dwell_nx = dwell_cnt - 8'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lin       <= '0;
      dwell_cnt <= '0;
      o_key_idx <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      lin       <= lin_nx;
      dwell_cnt <= dwell_nx;
      o_key_idx <= idx_nx;
    end

`ifdef RGB_FADE_GAMMA_EN
  logic [2:0][7:0] gam;
  always_comb begin
    gam = '0;
    for (int i = 0; i < 3; i++) gam[i] = 8'(({8'd0, lin[i]} * {8'd0, lin[i]}) >> 8);
  end
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) {o_red_duty, o_green_duty, o_blue_duty} <= '0;
    else {o_red_duty, o_green_duty, o_blue_duty} <= gam;
`else
  assign {o_red_duty, o_green_duty, o_blue_duty} = lin;
`endif
endmodule

// File: tb/tb_rgb_fade_scheduler.sv
// tb_rgb_fade_scheduler: keyframe-level reference model plus directed and random stimulus for rgb_fade_scheduler.
module tb_rgb_fade_scheduler;
  localparam int DIV = 4;
  localparam int NK  = 3;
  logic clk = 1'b0;
  logic rst, wr_en, start, stop;
  logic [1:0] wr_addr;
  logic [31:0] wr_data;
  logic busy, done;
  logic [1:0] key_idx;
  logic [7:0] red, green, blue;
  int checks = 0, errors = 0;
  int key_rgb [NK][3];
  int key_dwell [NK];
  int col [3];
  int gcol [3];
  int m_idx, m_left, m_cyc;
  bit m_active;

  always #5 clk = ~clk;

  rgb_fade_scheduler #(.CLK_DIV(DIV), .N_KEYS(NK), .KEY_AW(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_stop(stop), .o_busy(busy), .o_key_idx(key_idx), .o_key_done(done),
    .o_red_duty(red), .o_green_duty(green), .o_blue_duty(blue)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      key_dwell[k] = 0;
      for (int i = 0; i < 3; i++) key_rgb[k][i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      col[i] = 0;
      gcol[i] = 0;
    end
    m_active = 0;
    m_idx = 0;
    m_left = -1;
    m_cyc = 0;
  endtask

  function automatic bit model_tick();
    return m_active && (m_cyc % DIV == DIV - 1);
  endfunction

  task automatic compare();
    int e [3];
`ifdef RGB_FADE_GAMMA_EN
    e = gcol;
`else
    e = col;
`endif
    check("busy", int'(busy), int'(m_active));
    check("key_idx", int'(key_idx), m_idx);
    check("key_done", int'(done), int'(!stop && model_tick() && m_left == 0));
    check("red", int'(red), e[0]);
    check("green", int'(green), e[1]);
    check("blue", int'(blue), e[2]);
  endtask

  // Keyframe-level behaviour: m_left < 0 means still fading toward the current key.
  task automatic model_edge();
    bit tk, same;
    for (int i = 0; i < 3; i++) gcol[i] = (col[i] * col[i]) >> 8;
    tk = model_tick();
    if (stop) m_active = 0;
    else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_cyc = 0;
        m_idx = 0;
        m_left = -1;
      end
    end else begin
      if (tk) begin
        if (m_left < 0) begin
          same = 1;
          for (int i = 0; i < 3; i++) begin
            if (key_rgb[m_idx][i] > col[i]) col[i]++;
            else if (key_rgb[m_idx][i] < col[i]) col[i]--;
            if (col[i] != key_rgb[m_idx][i]) same = 0;
          end
          if (same) m_left = key_dwell[m_idx];
        end else if (m_left == 0) begin
          m_idx = (m_idx + 1) % NK;
          m_left = -1;
        end else m_left--;
      end
      m_cyc++;
    end
    if (wr_en && int'(wr_addr) < NK) begin
      key_dwell[wr_addr] = int'(wr_data[31:24]);
      key_rgb[wr_addr][0] = int'(wr_data[23:16]);
      key_rgb[wr_addr][1] = int'(wr_data[15:8]);
      key_rgb[wr_addr][2] = int'(wr_data[7:0]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(key_idx), 0);
    check("rst_done", int'(done), 0);
    check("rst_red", int'(red), 0);
    check("rst_green", int'(green), 0);
    check("rst_blue", int'(blue), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom % 6)
      0: return 8'd0;
      1: return 8'd255;
      2: return 8'd1;
      3: return 8'd254;
      4: return 8'($urandom % 16);
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    stop = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    // reset in the middle of a fade at red=37
    wr(0, {8'd0, 8'd200, 8'd0, 8'd0});
    go();
    run(148);
    check("red_at_37", int'(red), 37);
    do_reset();
    // all-zero table: done every two ticks
    go();
    run(8);
    check("zero_tbl_idx1", int'(key_idx), 1);
    run(16);
    check("zero_tbl_wrap", int'(key_idx), 0);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    // two-key fade/dwell sequence
    do_reset();
    wr(0, {8'd2, 8'd3, 8'd0, 8'd0});
    wr(1, {8'd0, 8'd0, 8'd0, 8'd2});
    go();
    run(4);
    check("seq_red_t1", int'(red), 1);
    run(8);
    check("seq_red_t3", int'(red), 3);
    run(11);
    check("seq_done_t6", int'(done), 1);
    check("seq_idx_t6", int'(key_idx), 0);
    run(1);
    check("seq_idx_after_t6", int'(key_idx), 1);
    run(12);
    check("seq_red_t9", int'(red), 0);
    check("seq_blue_t9", int'(blue), 2);
    run(3);
    check("seq_done_t10", int'(done), 1);
    run(1);
    check("seq_idx_t10", int'(key_idx), 2);
    // stop holds colour; start+stop stays idle
    do_reset();
    wr(0, {8'd0, 8'd200, 8'd0, 8'd0});
    go();
    run(400);
    check("stop_red_100", int'(red), 100);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    run(20);
    check("stop_red_held", int'(red), 100);
    check("stop_busy", int'(busy), 0);
    start = 1'b1;
    stop = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    run(2);
    check("start_stop_idle", int'(busy), 0);
    // live retarget and out-of-range write
    do_reset();
    wr(0, {8'd0, 8'd200, 8'd0, 8'd0});
    go();
    run(200);
    check("retarget_red_50", int'(red), 50);
    wr(0, {8'd0, 8'd10, 8'd0, 8'd0});
    run(3);
    check("retarget_red_49", int'(red), 49);
    wr(3, {8'd0, 8'd255, 8'd255, 8'd255});
    run(155);
    check("retarget_red_10", int'(red), 10);
`ifdef RGB_FADE_GAMMA_EN
    do_reset();
    wr(0, {8'd0, 8'd255, 8'd0, 8'd0});
    go();
    run(513);
    check("gamma_128", int'(red), 64);
    run(508);
    check("gamma_255", int'(red), 254);
`endif
    // randomized traffic
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      if (n == 3000) do_reset();
      wr_en = ($urandom % 12) == 0;
      wr_addr = 2'($urandom);
      wr_data = {8'($urandom % 4), pick(), pick(), pick()};
      start = ($urandom % 6) == 0;
      stop = ($urandom % 400) == 0;
      cycle();
    end
    wr_en = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
